// File: rtl/updown_count_checker.sv
// Step monitor for a 3-bit up/down counter: checks +/-1 transitions,
// tracks net wraps and counts illegal jumps with relock after a good run.
module updown_count_checker #(
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4,
  parameter int RELOCK = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     updown,
  input  logic [2:0]               count,
  output logic                     locked,
  output logic                     wrap_up,
  output logic                     wrap_down,
  output logic signed [WRAP_W-1:0] wrap_cnt,
  output logic                     err,
  output logic [ERR_W-1:0]         err_cnt,
  output logic [2:0]               last_bad
);

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    CHECK  = 2'd1,
    RESYNC = 2'd2
  } state_t;

  localparam logic signed [WRAP_W-1:0] WMAX =
    {1'b0, {(WRAP_W-1){1'b1}}};
  localparam logic signed [WRAP_W-1:0] WMIN =
    {1'b1, {(WRAP_W-1){1'b0}}};
  localparam logic [ERR_W-1:0] EMAX = '1;
  localparam logic [3:0] RELOCK_V = 4'(RELOCK);

  state_t state, state_nx;

  logic [2:0] prev_count;
  logic       prev_updown;
  logic [2:0] exp_count;
  logic       good;
  logic       up_wrap;
  logic       dn_wrap;

  logic [3:0] run, run_nx;
  logic       wrap_up_nx;
  logic       wrap_down_nx;
  logic signed [WRAP_W-1:0] wrap_cnt_nx;
  logic       err_nx;
  logic [ERR_W-1:0] err_cnt_nx;
  logic [2:0] last_bad_nx;

  assign locked = (state == CHECK);

  always_comb begin
    exp_count = prev_updown ? prev_count + 3'd1
                            : prev_count - 3'd1;
    good    = (count == exp_count);
    up_wrap = prev_updown && (prev_count == 3'd7)
              && (count == 3'd0);
    dn_wrap = !prev_updown && (prev_count == 3'd0)
              && (count == 3'd7);
  end

  always_comb begin
    state_nx     = state;
    run_nx       = run;
    wrap_up_nx   = 1'b0;
    wrap_down_nx = 1'b0;
    wrap_cnt_nx  = wrap_cnt;
    err_nx       = err;
    err_cnt_nx   = err_cnt;
    last_bad_nx  = last_bad;
    unique case (state)
      SYNC: state_nx = CHECK;
      CHECK: begin
        if (good) begin
          if (up_wrap) begin
            wrap_up_nx = 1'b1;
            if (wrap_cnt != WMAX)
              wrap_cnt_nx = wrap_cnt + 1'b1;
          end
          if (dn_wrap) begin
            wrap_down_nx = 1'b1;
            if (wrap_cnt != WMIN)
              wrap_cnt_nx = wrap_cnt - 1'b1;
          end
        end else begin
          err_nx      = 1'b1;
          last_bad_nx = count;
          run_nx      = 4'd0;
          state_nx    = RESYNC;
          if (err_cnt != EMAX)
            err_cnt_nx = err_cnt + 1'b1;
        end
      end
      RESYNC: begin
        if (good) begin
          if (run + 4'd1 == RELOCK_V) begin
            run_nx   = 4'd0;
            state_nx = CHECK;
          end else begin
            run_nx = run + 4'd1;
          end
        end else begin
          last_bad_nx = count;
          run_nx      = 4'd0;
          if (err_cnt != EMAX)
            err_cnt_nx = err_cnt + 1'b1;
        end
      end
      default: state_nx = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SYNC;
      run         <= 4'd0;
      prev_count  <= 3'd0;
      prev_updown <= 1'b0;
      wrap_up     <= 1'b0;
      wrap_down   <= 1'b0;
      wrap_cnt    <= '0;
      err         <= 1'b0;
      err_cnt     <= '0;
      last_bad    <= 3'd0;
    end else begin
      state       <= state_nx;
      run         <= run_nx;
      prev_count  <= count;
      prev_updown <= updown;
      wrap_up     <= wrap_up_nx;
      wrap_down   <= wrap_down_nx;
      wrap_cnt    <= wrap_cnt_nx;
      err         <= err_nx;
      err_cnt     <= err_cnt_nx;
      last_bad    <= last_bad_nx;
    end
  end

endmodule

// File: doc/updown_count_checker.md
Name: updown_count_checker

Overview:
- Downstream monitor for the 3-bit up/down counter. Samples the counter value and its updown control every clk.
- Checks each step against the expected ±1 (mod 8) transition and reports wrap-around events.
- Keeps a signed net-wrap count, so the 3-bit count can be extended to a wider position.
- Flags and counts illegal jumps, relocking after a run of good transitions. Sits between the counter and status/display logic.

Parameters:
- WRAP_W, 8: width of the signed net-wrap counter (two's complement, saturating).
- ERR_W, 4: width of the error counter (unsigned, saturating).
- RELOCK, 3: consecutive good transitions needed to leave RESYNC (range 1..15).

Ports:
- clk  input  1  rising-edge clock, same clock as the counter.
- reset  input  1  synchronous, active-high reset.
- updown  input  1  direction fed to the counter: 1 = up, 0 = down.
- count  input  3  counter output value.
- locked  output  1  high while in CHECK.
- wrap_up  output  1  one-cycle pulse on a valid 7->0 step while up.
- wrap_down  output  1  one-cycle pulse on a valid 0->7 step while down.
- wrap_cnt  output  WRAP_W  signed net wraps (up wraps minus down wraps).
- err  output  1  sticky error flag; cleared only by reset.
- err_cnt  output  ERR_W  number of bad transitions, saturating.
- last_bad  output  3  count value of the most recent bad transition.

Behaviour:
- Everything is synchronous to the rising edge of clk. Reset is synchronous, active-high, and dominates all other events.
- On reset: state=SYNC, locked=0, wrap_up=0, wrap_down=0, wrap_cnt=0, err=0, err_cnt=0, last_bad=0, good run counter=0, sample valid=0.
- Sample registers: every cycle not in reset, prev_count<=count and prev_updown<=updown.
- Expected value: exp = prev_updown ? prev_count+1 : prev_count-1, computed 3 bits wide, mod 8.
- Step at edge k+1: count is compared with exp formed from the samples taken at edge k. All outputs are registered, so results are visible one cycle after the compared count value appears.
- States:
  - SYNC: no comparison. Captures the first sample and moves to CHECK at the next edge.
  - CHECK: locked=1.
    - Good step: no error action.
    - Bad step (count!=exp): err<=1, err_cnt+1 (saturating), last_bad<=count, good run<=0, go to RESYNC.
  - RESYNC: locked=0.
    - Good step: good run+1. When it reaches RELOCK, go to CHECK and clear the good run counter.
    - Bad step: err_cnt+1 (saturating), last_bad<=count, good run<=0, stay in RESYNC.
- Wraps are counted only for good steps while in CHECK:
  - prev_count=7, prev_updown=1, count=0: wrap_up=1 for one cycle, wrap_cnt+1, saturating at 2^(WRAP_W-1)-1.
  - prev_count=0, prev_updown=0, count=7: wrap_down=1 for one cycle, wrap_cnt-1, saturating at -2^(WRAP_W-1).
  - wrap_up and wrap_down are never high together. Both are 0 in SYNC and RESYNC.
- Direction change: exp always uses the sampled prev_updown, so a reversal (e.g. 5 up, then updown=0 gives 6 then 5) is a good step.
- A held value (count==prev_count) is a bad step.
- Saturation: err_cnt holds at 2^ERR_W-1. err remains 1.
- Reset in any state, including mid-RESYNC or during a wrap pulse: the next cycle shows reset values, and wrap pulses in flight are cancelled.

Test Plan:
- Reset 1 cycle, updown=1 for 10 cycles (count 0..7,0,1,2) -> locked=1 from 2nd cycle; one wrap_up pulse the cycle after count=0; wrap_cnt=1; err=0.
- Continue with updown=0 for 4 cycles (2,1,0,7,6) -> one wrap_down pulse after count=7; wrap_cnt=0; no err.
- Force a count step 3->5 with updown=1 -> next cycle err=1, err_cnt=1, last_bad=5, locked=0; after 3 good steps locked=1 while err stays 1; a 7->0 during RESYNC gives no wrap_up.
- WRAP_W=4, 10 consecutive up wraps -> wrap_cnt saturates at 7. ERR_W=4, 20 injected bad steps -> err_cnt holds at 15.
- Assert reset during RESYNC at the same edge as a bad step -> next cycle all outputs are 0, state=SYNC, err_cnt=0; normal counting then relocks after 2 cycles.
